regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 147 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: round-robin over alu/mem/mdu into one register-file write port,
// with a pending-write scoreboard set at issue and cleared at writeback.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic                  mem_valid,
    input  logic                  mdu_valid,
    output logic                  alu_ready,
    output logic                  mem_ready,
    output logic                  mdu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [ADDR_WIDTH-1:0] mdu_addr,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mdu_data,
    output logic                  reg_write,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic [ADDR_WIDTH-1:0] chk_addr_1,
    input  logic [ADDR_WIDTH-1:0] chk_addr_2,
    output logic                  busy_1,
    output logic                  busy_2
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [2:0]            vld;
    logic [2:0]            gnt;
    logic [1:0]            ptr_q;
    logic [1:0]            ptr_nxt;
    logic                  hs;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NREG-1:0]       busy_q;
    logic [NREG-1:0]       set_vec;
    logic [NREG-1:0]       clr_vec;
    logic [NREG-1:0]       busy_nxt;

    assign vld = {mdu_valid, mem_valid, alu_valid};

    // Round-robin grant starting at ptr; nothing granted while in reset.
    always_comb begin
        gnt = 3'b000;
        if (!reset) begin
            case (ptr_q)
                2'd1: begin
                    if (vld[1])      gnt = 3'b010;
                    else if (vld[2]) gnt = 3'b100;
                    else if (vld[0]) gnt = 3'b001;
                end
                2'd2: begin
                    if (vld[2])      gnt = 3'b100;
                    else if (vld[0]) gnt = 3'b001;
                    else if (vld[1]) gnt = 3'b010;
                end
                default: begin
                    if (vld[0])      gnt = 3'b001;
                    else if (vld[1]) gnt = 3'b010;
                    else if (vld[2]) gnt = 3'b100;
                end
            endcase
        end
    end

    assign alu_ready = gnt[0];
    assign mem_ready = gnt[1];
    assign mdu_ready = gnt[2];
    assign hs        = |gnt;

    // Select the granted request and advance the pointer past the winner.
    always_comb begin
        sel_addr = alu_addr;
        sel_data = alu_data;
        ptr_nxt  = ptr_q;
        unique case (1'b1)
            gnt[0]: begin
                sel_addr = alu_addr;
                sel_data = alu_data;
                ptr_nxt  = 2'd1;
            end
            gnt[1]: begin
                sel_addr = mem_addr;
                sel_data = mem_data;
                ptr_nxt  = 2'd2;
            end
            gnt[2]: begin
                sel_addr = mdu_addr;
                sel_data = mdu_data;
                ptr_nxt  = 2'd0;
            end
            default: begin
                ptr_nxt = ptr_q;
            end
        endcase
    end

    // Scoreboard update: clear on writeback, set on issue; set wins on a tie.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_valid && (iss_rd != '0)) begin
            set_vec[iss_rd] = 1'b1;
        end
        if (hs) begin
            clr_vec[sel_addr] = 1'b1;
        end
        busy_nxt    = (busy_q & ~clr_vec) | set_vec;
        busy_nxt[0] = 1'b0;
    end

    // Arbitration pointer and registered write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= 2'd0;
            reg_write  <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
        end else begin
            ptr_q     <= ptr_nxt;
            reg_write <= hs && (sel_addr != '0);
            if (hs) begin
                write_addr <= sel_addr;
                write_data <= sel_data;
            end
        end
    end

    // Pending-write scoreboard state.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    assign busy_1 = busy_q[chk_addr_1];
    assign busy_2 = busy_q[chk_addr_2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration order, write
// latency, x0 handling, scoreboard set/clear and reset behaviour.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        alu_valid, mem_valid, mdu_valid;
    logic        alu_ready, mem_ready, mdu_ready;
    logic [4:0]  alu_addr, mem_addr, mdu_addr;
    logic [31:0] alu_data, mem_data, mdu_data;
    logic        reg_write;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  chk_addr_1, chk_addr_2;
    logic        busy_1, busy_2;

    int pass_cnt = 0;
    int total_cnt = 0;

    regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .mem_valid(mem_valid), .mdu_valid(mdu_valid),
        .alu_ready(alu_ready), .mem_ready(mem_ready), .mdu_ready(mdu_ready),
        .alu_addr(alu_addr), .mem_addr(mem_addr), .mdu_addr(mdu_addr),
        .alu_data(alu_data), .mem_data(mem_data), .mdu_data(mdu_data),
        .reg_write(reg_write), .write_addr(write_addr), .write_data(write_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .chk_addr_1(chk_addr_1), .chk_addr_2(chk_addr_2),
        .busy_1(busy_1), .busy_2(busy_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are then driven 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alu_valid = 0; mem_valid = 0; mdu_valid = 0;
        alu_addr = 0; mem_addr = 0; mdu_addr = 0;
        alu_data = 0; mem_data = 0; mdu_data = 0;
        iss_valid = 0; iss_rd = 0;
        chk_addr_1 = 0; chk_addr_2 = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        alu_valid = 1; alu_addr = 5'd4; alu_data = 32'hAA;
        iss_valid = 1; iss_rd = 5'd4;
        chk_addr_1 = 5'd4;
        #1;
        total_cnt++;
        if ({mdu_ready, mem_ready, alu_ready} !== 3'b000)
            $display("FAIL reset_ready got=%b exp=000",
                     {mdu_ready, mem_ready, alu_ready});
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if ({reg_write, write_addr, write_data} !== 38'd0)
            $display("FAIL reset_wport got=%b/%0d/%h exp=0/0/0",
                     reg_write, write_addr, write_data);
        else pass_cnt++;
        total_cnt++;
        if (busy_1 !== 1'b0)
            $display("FAIL reset_iss_ignored got=%b exp=0", busy_1);
        else pass_cnt++;
        clear_inputs();
    endtask

    task automatic test_single_write();
        reset = 0;
        alu_valid = 1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        total_cnt++;
        if ({mdu_ready, mem_ready, alu_ready} !== 3'b001)
            $display("FAIL single_ready got=%b exp=001",
                     {mdu_ready, mem_ready, alu_ready});
        else pass_cnt++;
        tick();
        alu_valid = 0;
        total_cnt++;
        if (reg_write !== 1'b1 || write_addr !== 5'd5 ||
            write_data !== 32'hDEADBEEF)
            $display("FAIL single_write got=%b/%0d/%h exp=1/5/deadbeef",
                     reg_write, write_addr, write_data);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (reg_write !== 1'b0 || write_addr !== 5'd5 ||
            write_data !== 32'hDEADBEEF)
            $display("FAIL idle_hold got=%b/%0d/%h exp=0/5/deadbeef",
                     reg_write, write_addr, write_data);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_gnt;
        clear_inputs();
        reset = 1;
        tick();
        reset = 0;
        alu_valid = 1; alu_addr = 5'd1; alu_data = 32'h11;
        mem_valid = 1; mem_addr = 5'd2; mem_data = 32'h22;
        mdu_valid = 1; mdu_addr = 5'd3; mdu_data = 32'h33;
        for (int i = 0; i < 6; i++) begin
            exp_gnt = 3'b001 << (i % 3);
            #1;
            total_cnt++;
            if ({mdu_ready, mem_ready, alu_ready} !== exp_gnt)
                $display("FAIL rr_grant[%0d] got=%b exp=%b", i,
                         {mdu_ready, mem_ready, alu_ready}, exp_gnt);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (reg_write !== 1'b1 || write_addr !== 5'((i % 3) + 1) ||
                write_data !== 32'(((i % 3) + 1) * 32'h11))
                $display("FAIL rr_write[%0d] got=%b/%0d/%h exp=1/%0d/%h",
                         i, reg_write, write_addr, write_data,
                         (i % 3) + 1, ((i % 3) + 1) * 32'h11);
            else pass_cnt++;
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_addr_zero();
        mem_valid = 1; mem_addr = 5'd0; mem_data = 32'h1234;
        chk_addr_1 = 5'd0;
        #1;
        total_cnt++;
        if (mem_ready !== 1'b1)
            $display("FAIL x0_ready got=%b exp=1", mem_ready);
        else pass_cnt++;
        tick();
        mem_valid = 0;
        total_cnt++;
        if (reg_write !== 1'b0)
            $display("FAIL x0_no_write got=%b exp=0", reg_write);
        else pass_cnt++;
        total_cnt++;
        if (busy_1 !== 1'b0)
            $display("FAIL x0_busy got=%b exp=0", busy_1);
        else pass_cnt++;
        clear_inputs();
    endtask

    task automatic test_scoreboard();
        iss_valid = 1; iss_rd = 5'd7;
        chk_addr_1 = 5'd7; chk_addr_2 = 5'd8;
        #1;
        total_cnt++;
        if (busy_1 !== 1'b0)
            $display("FAIL sb_no_bypass got=%b exp=0", busy_1);
        else pass_cnt++;
        tick();
        iss_valid = 0;
        total_cnt++;
        if (busy_1 !== 1'b1 || busy_2 !== 1'b0)
            $display("FAIL sb_set got=%b%b exp=10", busy_1, busy_2);
        else pass_cnt++;
        mdu_valid = 1; mdu_addr = 5'd7; mdu_data = 32'h77;
        #1;
        total_cnt++;
        if (mdu_ready !== 1'b1)
            $display("FAIL sb_mdu_ready got=%b exp=1", mdu_ready);
        else pass_cnt++;
        tick();
        mdu_valid = 0;
        total_cnt++;
        if (busy_1 !== 1'b0 || reg_write !== 1'b1 || write_addr !== 5'd7)
            $display("FAIL sb_clear got=%b/%b/%0d exp=0/1/7",
                     busy_1, reg_write, write_addr);
        else pass_cnt++;
        iss_valid = 1; iss_rd = 5'd11;
        tick();
        iss_rd = 5'd10;
        alu_valid = 1; alu_addr = 5'd11; alu_data = 32'hB;
        chk_addr_1 = 5'd10; chk_addr_2 = 5'd11;
        tick();
        clear_inputs();
        chk_addr_1 = 5'd10; chk_addr_2 = 5'd11;
        #1;
        total_cnt++;
        if (busy_1 !== 1'b1 || busy_2 !== 1'b0)
            $display("FAIL sb_set_clr_diff got=%b%b exp=10", busy_1, busy_2);
        else pass_cnt++;
        mem_valid = 1; mem_addr = 5'd12; mem_data = 32'hC;
        chk_addr_2 = 5'd12;
        tick();
        mem_valid = 0;
        total_cnt++;
        if (busy_2 !== 1'b0 || busy_1 !== 1'b1)
            $display("FAIL sb_clr_idle got=%b%b exp=10", busy_1, busy_2);
        else pass_cnt++;
        clear_inputs();
    endtask

    task automatic test_set_clear_same();
        iss_valid = 1; iss_rd = 5'd9;
        chk_addr_1 = 5'd9;
        tick();
        alu_valid = 1; alu_addr = 5'd9; alu_data = 32'h99;
        #1;
        total_cnt++;
        if (busy_1 !== 1'b1 || alu_ready !== 1'b1)
            $display("FAIL same_pre got=%b/%b exp=1/1", busy_1, alu_ready);
        else pass_cnt++;
        tick();
        clear_inputs();
        chk_addr_1 = 5'd9;
        #1;
        total_cnt++;
        if (busy_1 !== 1'b1 || reg_write !== 1'b1 || write_addr !== 5'd9)
            $display("FAIL same_set_wins got=%b/%b/%0d exp=1/1/9",
                     busy_1, reg_write, write_addr);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_midflight();
        clear_inputs();
        mem_valid = 1; mem_addr = 5'd6; mem_data = 32'h66;
        iss_valid = 1; iss_rd = 5'd3;
        chk_addr_1 = 5'd3;
        tick();
        clear_inputs();
        chk_addr_1 = 5'd3;
        #1;
        total_cnt++;
        if (busy_1 !== 1'b1)
            $display("FAIL mid_pre_busy got=%b exp=1", busy_1);
        else pass_cnt++;
        alu_valid = 1; alu_addr = 5'd20; alu_data = 32'hA0;
        mem_valid = 1; mem_addr = 5'd21; mem_data = 32'hA1;
        reset = 1;
        #1;
        total_cnt++;
        if ({mdu_ready, mem_ready, alu_ready} !== 3'b000)
            $display("FAIL mid_ready got=%b exp=000",
                     {mdu_ready, mem_ready, alu_ready});
        else pass_cnt++;
        tick();
        reset = 0;
        total_cnt++;
        if (reg_write !== 1'b0 || busy_1 !== 1'b0)
            $display("FAIL mid_dropped got=%b/%b exp=0/0", reg_write, busy_1);
        else pass_cnt++;
        #1;
        total_cnt++;
        if ({mdu_ready, mem_ready, alu_ready} !== 3'b001)
            $display("FAIL mid_alu_first got=%b exp=001",
                     {mdu_ready, mem_ready, alu_ready});
        else pass_cnt++;
        tick();
        clear_inputs();
        total_cnt++;
        if (reg_write !== 1'b1 || write_addr !== 5'd20)
            $display("FAIL mid_post_write got=%b/%0d exp=1/20",
                     reg_write, write_addr);
        else pass_cnt++;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        test_reset();
        test_single_write();
        test_round_robin();
        test_addr_zero();
        test_scoreboard();
        test_set_clear_same();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
